// File: rtl/fx2_pkg.sv
// Shared constants for the FX2 shift/rotate issue controller and its element shifter.
package fx2_pkg;

    localparam int DATA_W = 128;
    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int NWORD  = DATA_W / WORD_W;
    localparam int NHALF  = DATA_W / HALF_W;
    localparam int WCNT_W = 6;
    localparam int HCNT_W = 5;

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHLH = 3'd1;
    localparam logic [2:0] OP_ROT  = 3'd2;
    localparam logic [2:0] OP_ROTH = 3'd3;

    localparam logic [5:0] MASK_SHL  = 6'h3F;
    localparam logic [4:0] MASK_SHLH = 5'h1F;
    localparam logic [4:0] MASK_ROT  = 5'h1F;
    localparam logic [3:0] MASK_ROTH = 4'h0F;

    // Immediate counts are signed; -1 must become an all-ones count before masking.
    function automatic logic signed [7:0] sext_imm7(input logic [6:0] imm);
        return {imm[6], imm};
    endfunction

endpackage

// File: rtl/fx2_elem_shifter.sv
// Combinational per-element shifter/rotator: word ops use four 6-bit counts,
// halfword ops use eight 5-bit counts; reserved opcodes pass ra through.
module fx2_elem_shifter
    import fx2_pkg::*;
(
    input  logic [DATA_W-1:0]       ra,
    input  logic [NWORD*WCNT_W-1:0] wcnt,
    input  logic [NHALF*HCNT_W-1:0] hcnt,
    input  logic [2:0]              op,
    output logic [DATA_W-1:0]       result
);

    // Counts of 32 or more clear the word entirely.
    function automatic logic [WORD_W-1:0] shl32(input logic [WORD_W-1:0] v, input logic [5:0] c);
        return c[5] ? '0 : (v << c[4:0]);
    endfunction

    // Counts of 16 or more clear the halfword entirely.
    function automatic logic [HALF_W-1:0] shl16(input logic [HALF_W-1:0] v, input logic [4:0] c);
        return c[4] ? '0 : (v << c[3:0]);
    endfunction

    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] v, input logic [4:0] c);
        logic [2*WORD_W-1:0] d;
        d = {v, v} << c;
        return d[2*WORD_W-1:WORD_W];
    endfunction

    function automatic logic [HALF_W-1:0] rotl16(input logic [HALF_W-1:0] v, input logic [3:0] c);
        logic [2*HALF_W-1:0] d;
        d = {v, v} << c;
        return d[2*HALF_W-1:HALF_W];
    endfunction

    // Apply the selected operation independently to every element.
    always_comb begin
        result = ra;
        case (op)
            OP_SHL: begin
                for (int k = 0; k < NWORD; k++)
                    result[WORD_W*k +: WORD_W] = shl32(ra[WORD_W*k +: WORD_W], wcnt[WCNT_W*k +: WCNT_W]);
            end
            OP_ROT: begin
                for (int k = 0; k < NWORD; k++)
                    result[WORD_W*k +: WORD_W] = rotl32(ra[WORD_W*k +: WORD_W], wcnt[WCNT_W*k +: 5]);
            end
            OP_SHLH: begin
                for (int k = 0; k < NHALF; k++)
                    result[HALF_W*k +: HALF_W] = shl16(ra[HALF_W*k +: HALF_W], hcnt[HCNT_W*k +: HCNT_W]);
            end
            OP_ROTH: begin
                for (int k = 0; k < NHALF; k++)
                    result[HALF_W*k +: HALF_W] = rotl16(ra[HALF_W*k +: HALF_W], hcnt[HCNT_W*k +: 4]);
            end
            default: result = ra;
        endcase
    end

endmodule

// File: rtl/fx2_shift_ctrl.sv
// FX2 shift/rotate issue controller: four-stage pipeline (latch, count, shift,
// result) with a global stall from the writeback handshake and a synchronous flush.
module fx2_shift_ctrl
    import fx2_pkg::*;
#(
    parameter int LAT  = 4,
    parameter int TAGW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic              in_use_imm,
    input  logic [6:0]        in_imm7,
    input  logic [DATA_W-1:0] in_ra,
    input  logic [DATA_W-1:0] in_rb,
    input  logic [TAGW-1:0]   in_rt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAGW-1:0]   out_rt
);

    logic              stall;
    logic              accept;
    logic [LAT:1]      vld_p;

    logic [2:0]        op_p1;
    logic              use_imm_p1;
    logic [6:0]        imm_p1;
    logic [DATA_W-1:0] ra_p1;
    logic [DATA_W-1:0] rb_p1;
    logic [TAGW-1:0]   rt_p1;

    logic [2:0]              op_p2;
    logic [DATA_W-1:0]       ra_p2;
    logic [TAGW-1:0]         rt_p2;
    logic [NWORD*WCNT_W-1:0] wcnt_p2;
    logic [NHALF*HCNT_W-1:0] hcnt_p2;

    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] result_p3;
    logic [TAGW-1:0]   rt_p3;

    logic unused_rb;

    // Only the low count bits of each rb element matter.
    assign unused_rb = ^rb_p1;

    // Word counts: SHL keeps 6 bits (>=32 clears), ROT keeps 5 bits (mod 32).
    function automatic logic [NWORD*WCNT_W-1:0] word_counts(
        input logic [2:0] op, input logic use_imm, input logic [6:0] imm, input logic [DATA_W-1:0] rb);
        logic [NWORD*WCNT_W-1:0] res;
        logic [WCNT_W-1:0]       mask;
        logic [WCNT_W-1:0]       c;
        logic signed [7:0]       simm;
        mask = (op == OP_ROT) ? {1'b0, MASK_ROT} : MASK_SHL;
        simm = sext_imm7(imm);
        for (int k = 0; k < NWORD; k++) begin
            c = use_imm ? simm[WCNT_W-1:0] : rb[WORD_W*k +: WCNT_W];
            res[WCNT_W*k +: WCNT_W] = c & mask;
        end
        return res;
    endfunction

    // Halfword counts: SHLH keeps 5 bits (>=16 clears), ROTH keeps 4 bits (mod 16).
    function automatic logic [NHALF*HCNT_W-1:0] half_counts(
        input logic [2:0] op, input logic use_imm, input logic [6:0] imm, input logic [DATA_W-1:0] rb);
        logic [NHALF*HCNT_W-1:0] res;
        logic [HCNT_W-1:0]       mask;
        logic [HCNT_W-1:0]       c;
        logic signed [7:0]       simm;
        mask = (op == OP_ROTH) ? {1'b0, MASK_ROTH} : MASK_SHLH;
        simm = sext_imm7(imm);
        for (int k = 0; k < NHALF; k++) begin
            c = use_imm ? simm[HCNT_W-1:0] : rb[HALF_W*k +: HCNT_W];
            res[HCNT_W*k +: HCNT_W] = c & mask;
        end
        return res;
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst & ~stall & ~flush;
    assign accept   = in_valid & in_ready;
    assign out_valid = vld_p[LAT];

    // Valid chain: flush and reset empty every stage; a stall freezes all of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p <= '0;
        else if (flush)
            vld_p <= '0;
        else if (!stall)
            vld_p <= {vld_p[LAT-1:1], accept};
    end

    // S1 operand latch, S2 count derivation, S3 element shift; all advance together.
    always_ff @(posedge clk) begin
        if (!stall) begin
            // S1: latch issue operands
            op_p1      <= in_op;
            use_imm_p1 <= in_use_imm;
            imm_p1     <= in_imm7;
            ra_p1      <= in_ra;
            rb_p1      <= in_rb;
            rt_p1      <= in_rt;
            // S2: per-element counts
            op_p2      <= op_p1;
            ra_p2      <= ra_p1;
            rt_p2      <= rt_p1;
            wcnt_p2    <= word_counts(op_p1, use_imm_p1, imm_p1, rb_p1);
            hcnt_p2    <= half_counts(op_p1, use_imm_p1, imm_p1, rb_p1);
            // S3: shifted value
            result_p3  <= shift_res;
            rt_p3      <= rt_p2;
        end
    end

    fx2_elem_shifter u_shifter (
        .ra     (ra_p2),
        .wcnt   (wcnt_p2),
        .hcnt   (hcnt_p2),
        .op     (op_p2),
        .result (shift_res)
    );

    // S4: result register feeding writeback; held stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_rt     <= '0;
        end else if (!stall) begin
            out_result <= result_p3;
            out_rt     <= rt_p3;
        end
    end

endmodule

// File: tb/tb_fx2_shift_ctrl.sv
// Randomized bench for fx2_shift_ctrl against an element-level arithmetic model
// with an in-order scoreboard tracking each op's pipeline age.
module tb_fx2_shift_ctrl;

    localparam int TAGW = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_op;
    logic           in_use_imm;
    logic [6:0]     in_imm7;
    logic [127:0]   in_ra;
    logic [127:0]   in_rb;
    logic [TAGW-1:0] in_rt;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_result;
    logic [TAGW-1:0] out_rt;

    always #5 clk = ~clk;

    fx2_shift_ctrl #(.LAT(4), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_use_imm (in_use_imm),
        .in_imm7    (in_imm7),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_rt      (in_rt),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rt     (out_rt)
    );

    typedef struct {
        int              age;
        logic [127:0]    res;
        logic [TAGW-1:0] tag;
    } ent_t;

    ent_t q[$];
    int   npass = 0;
    int   ntot  = 0;
    bit   last_accept;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Element-wise reference computed from the instruction semantics.
    function automatic logic [127:0] model(input logic [2:0] op, input logic ui,
                                           input logic [6:0] imm, input logic [127:0] ra,
                                           input logic [127:0] rb);
        logic [127:0] r;
        longint simm, v, c, e;
        simm = imm[6] ? longint'(imm) - 128 : longint'(imm);
        r = ra;
        if (op == 3'd0 || op == 3'd2) begin
            for (int k = 0; k < 4; k++) begin
                v = longint'(ra[32*k +: 32]);
                c = ui ? simm : longint'(rb[32*k +: 32]);
                if (op == 3'd0) begin
                    c = c & 63;
                    e = (c >= 32) ? 0 : ((v << c) & 64'hFFFF_FFFF);
                end else begin
                    c = c & 31;
                    e = ((v << c) | (v >> (32 - c))) & 64'hFFFF_FFFF;
                end
                r[32*k +: 32] = e[31:0];
            end
        end else if (op == 3'd1 || op == 3'd3) begin
            for (int k = 0; k < 8; k++) begin
                v = longint'(ra[16*k +: 16]);
                c = ui ? simm : longint'(rb[16*k +: 16]);
                if (op == 3'd1) begin
                    c = c & 31;
                    e = (c >= 16) ? 0 : ((v << c) & 64'hFFFF);
                end else begin
                    c = c & 15;
                    e = ((v << c) | (v >> (16 - c))) & 64'hFFFF;
                end
                r[16*k +: 16] = e[15:0];
            end
        end
        return r;
    endfunction

    // Evaluate one cycle (inputs already driven at the negedge), then advance the model.
    task automatic tick();
        bit exp_valid, exp_stall, exp_rdy;
        #1;
        exp_valid = (q.size() > 0) && (q[0].age == 4);
        exp_stall = exp_valid && !out_ready;
        exp_rdy   = !exp_stall && !flush;
        check("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
        check("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
        if (exp_valid && out_valid) begin
            check("result", out_result, q[0].res);
            check("tag", {121'd0, out_rt}, {121'd0, q[0].tag});
        end
        last_accept = 1'b0;
        if (flush) begin
            q.delete();
        end else if (!exp_stall) begin
            if (exp_valid && out_ready) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_valid && exp_rdy) begin
                q.push_back('{1, model(in_op, in_use_imm, in_imm7, in_ra, in_rb), in_rt});
                last_accept = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [2:0] op, input logic ui, input logic [6:0] imm,
                          input logic [127:0] ra, input logic [127:0] rb, input logic [TAGW-1:0] rt);
        in_valid = 1'b1; in_op = op; in_use_imm = ui; in_imm7 = imm;
        in_ra = ra; in_rb = rb; in_rt = rt;
    endtask

    task automatic set_rand_op(input logic [TAGW-1:0] rt);
        logic [127:0] rb;
        rb = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 0) rb = rb & {8{16'h003F}};
        set_op(3'($urandom_range(0, 7)), 1'($urandom), 7'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, rb, rt);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        check("drained", {127'd0, q.size() == 0}, 128'd1);
        for (int i = 0; i < 3; i++) tick();
    endtask

    int j;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_use_imm = 1'b0; in_imm7 = '0;
        in_ra = '0; in_rb = '0; in_rt = '0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_result", out_result, 128'd0);
        check("rst_out_rt", {121'd0, out_rt}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed shifts and rotates, issued back to back.
        set_op(3'd0, 1'b1, 7'd1, {4{32'h8000_0001}}, '0, 7'd1); tick();
        set_op(3'd0, 1'b1, 7'h7F, {4{32'h8000_0001}}, '0, 7'd2); tick();
        set_op(3'd1, 1'b0, 7'd0, {8{16'hFFFF}},
               {16'd16, 16'd15, 16'd1, 16'd0, 16'd16, 16'd15, 16'd1, 16'd0}, 7'd3); tick();
        set_op(3'd2, 1'b1, 7'd36, {4{32'h1234_5678}}, '0, 7'd4); tick();
        set_op(3'd2, 1'b0, 7'd0, {4{32'h1234_5678}}, {4{32'd36}}, 7'd5); tick();
        set_op(3'd3, 1'b1, 7'h7F, {8{16'h8001}}, '0, 7'd6); tick();
        set_op(3'd5, 1'b0, 7'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '1, 7'd7); tick();
        drain();

        // Eight back-to-back ops with writeback stalled in cycles 5-7.
        j = 0;
        for (int c = 0; c < 40 && (j < 8 || q.size() > 0); c++) begin
            out_ready = !(c >= 5 && c <= 7);
            if (j < 8) set_rand_op(7'(16 + j)); else in_valid = 1'b0;
            tick();
            if (last_accept) j++;
        end
        check("b2b_issued", 128'(j), 128'd8);
        drain();

        // Flush while stalled with four ops in flight, then issue right after.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin set_rand_op(7'(32 + i)); tick(); end
        in_valid = 1'b0; tick();
        set_rand_op(7'd99); flush = 1'b1; tick();
        flush = 1'b0; out_ready = 1'b1; set_rand_op(7'd77); tick();
        in_valid = 1'b0;
        drain();

        // Randomized traffic with stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) set_rand_op(7'($urandom)); else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 99) < 3);
            if (flush) out_ready = 1'b0;
            tick();
        end
        flush = 1'b0;
        drain();

        // Reset with three ops in flight: outputs clear at once, nothing stale emerges.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin set_rand_op(7'(48 + i)); tick(); end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_out_result", out_result, 128'd0);
        check("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        set_op(3'd0, 1'b1, 7'd4, {4{32'h0000_000F}}, '0, 7'd60); tick();
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", npass, ntot);
        $fatal(1, "timeout");
    end

endmodule
